riscv_imem_arb: RTL and testbench
=================================

RISCV_IMEM_ARB -- requirements
Module: riscv_imem_arb

Interface
REQ-001 Parameter PC_WIDTH, default 15, byte-address width of both requesters.
REQ-002 Parameter INST_WIDTH, default 32, data width.
REQ-003 Parameter MEM_LAT, default 1, legal 1..4, cycles from mem_en to valid mem_rdata.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 f_req / f_addr / f_flush  in  1 / PC_WIDTH / 1  fetch request, byte address, flush of pending fetch.
REQ-008 f_gnt / f_rvalid / f_err / f_rdata  out  1 / 1 / 1 / INST_WIDTH  fetch grant pulse, response pulse, misalign error, instruction.
REQ-009 l_req / l_we / l_addr / l_wdata  in  1 / 1 / PC_WIDTH / INST_WIDTH  loader request, write enable, byte address, write data.
REQ-010 l_gnt / l_rvalid / l_err / l_rdata  out  1 / 1 / 1 / INST_WIDTH  loader grant, response, error, read data.
REQ-011 mem_en / mem_we / mem_addr / mem_wdata  out  1 / 1 / PC_WIDTH-2 / INST_WIDTH  single-port instruction memory access.
REQ-012 mem_rdata  in  INST_WIDTH  memory read data, valid MEM_LAT cycles after mem_en.

Function
REQ-013 FSM states SHALL be IDLE, WAIT, RESP; one transaction outstanding at a time.
REQ-014 Requester SHALL hold req and address/data stable until its gnt; gnt is a one-cycle pulse, combinational in IDLE only.
REQ-015 Arbitration in IDLE: single requester wins; both requesting -> grant the one not granted last (round-robin, last_gnt register).
REQ-016 f_req SHALL be ignored in any cycle f_flush=1.
REQ-017 Aligned grant at cycle T: mem_en=1, mem_we=l_we (loader) or 0 (fetch), mem_addr=addr[PC_WIDTH-1:2], mem_wdata=l_wdata, all in cycle T only; FSM -> WAIT.
REQ-018 WAIT SHALL last MEM_LAT cycles (counter); mem_rdata captured into response register at cycle T+MEM_LAT; FSM -> RESP.
REQ-019 RESP at T+MEM_LAT+1: granted side's rvalid=1 for one cycle, rdata=captured word (0 for loader writes), err=0; FSM -> IDLE; next grant earliest T+MEM_LAT+2.
REQ-020 Misaligned grant (addr[1:0]!=0): no mem_en; FSM -> RESP at T+1 with err=1, rdata=0.
REQ-021 f_flush=1 in any cycle between a fetch grant and its RESP (inclusive) SHALL suppress that f_rvalid/f_err; memory-side timing and FSM unchanged.
REQ-022 rvalid/err/rdata of the non-granted side SHALL be 0; f_rdata/l_rdata SHALL be 0 whenever its rvalid=0.
REQ-023 Requests arriving while not IDLE SHALL wait; no grant, no loss.

Reset
REQ-024 reset=1 at a clock edge SHALL force IDLE, counter=0, response register=0, last_gnt=loader (fetch wins first tie).
REQ-025 During and after reset all outputs SHALL be 0; an in-flight response SHALL be dropped, never emitted.

Verification
REQ-026 MEM_LAT=1, f_req, f_addr=0x0010, mem_rdata=0x00500093 -> f_gnt cycle T, mem_addr=0x004, f_rvalid with f_rdata=0x00500093 at T+2.
REQ-027 f_req and l_req both held from reset release -> grants fetch, loader, fetch, loader at T, T+3, T+6, T+9 (MEM_LAT=1).
REQ-028 l_req, l_we=1, l_addr=0x0020, l_wdata=0xDEADBEEF -> mem_en=1, mem_we=1, mem_addr=0x008, mem_wdata=0xDEADBEEF at T; l_rvalid=1, l_rdata=0 at T+2.
REQ-029 f_addr=0x0006 -> no mem_en, f_rvalid=1, f_err=1, f_rdata=0 at T+1.
REQ-030 MEM_LAT=3 fetch, f_flush=1 at T+2 -> f_rvalid never asserted; next grant possible at T+5.
REQ-031 reset=1 at T+1 of a fetch -> all outputs 0, no f_rvalid; after release, pending l_req and f_req tie grants fetch first.

Source files
------------

// File: rtl/riscv_imem_arb.sv
// Two-requester (fetch/loader) arbiter onto a single-port instruction memory, one transaction at a time.
// Grant is combinational in IDLE; response arrives MEM_LAT+1 cycles after an aligned grant, 1 cycle after a misaligned one.
// Requesters are backpressured by withholding grant until IDLE; a waiting request is never dropped.
module riscv_imem_arb #(
    parameter int PC_WIDTH   = 15,
    parameter int INST_WIDTH = 32,
    parameter int MEM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  f_req,
    input  logic [PC_WIDTH-1:0]   f_addr,
    input  logic                  f_flush,
    output logic                  f_gnt,
    output logic                  f_rvalid,
    output logic                  f_err,
    output logic [INST_WIDTH-1:0] f_rdata,
    input  logic                  l_req,
    input  logic                  l_we,
    input  logic [PC_WIDTH-1:0]   l_addr,
    input  logic [INST_WIDTH-1:0] l_wdata,
    output logic                  l_gnt,
    output logic                  l_rvalid,
    output logic                  l_err,
    output logic [INST_WIDTH-1:0] l_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [PC_WIDTH-3:0]   mem_addr,
    output logic [INST_WIDTH-1:0] mem_wdata,
    input  logic [INST_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

    state_t                r_state, w_state_nxt;
    logic [1:0]            r_cnt, w_cnt_nxt;
    logic                  r_sel;   // 1 = loader owns the outstanding transaction
    logic                  r_last;  // 1 = loader won the most recent grant
    logic                  r_we;
    logic                  r_err;
    logic                  r_flush;
    logic [INST_WIDTH-1:0] r_rdata;

    logic                  w_f_req, w_idle, w_pick_l, w_any, w_aligned, w_resp;
    logic [PC_WIDTH-1:0]   w_addr;

    always_comb begin
        w_f_req   = f_req & ~f_flush;
        w_idle    = (r_state == S_IDLE) & ~reset;
        w_pick_l  = l_req & (~w_f_req | ~r_last);
        f_gnt     = w_idle & w_f_req & ~w_pick_l;
        l_gnt     = w_idle & w_pick_l;
        w_any     = f_gnt | l_gnt;
        w_addr    = l_gnt ? l_addr : f_addr;
        w_aligned = (w_addr[1:0] == 2'b00);
        mem_en    = w_any & w_aligned;
        mem_we    = mem_en & l_gnt & l_we;
        mem_addr  = mem_en ? w_addr[PC_WIDTH-1:2] : '0;
        mem_wdata = mem_en ? l_wdata : '0;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    if (w_aligned) begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = LAT_M1;
                    end else begin
                        w_state_nxt = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 2'd0) w_state_nxt = S_RESP;
                else               w_cnt_nxt   = r_cnt - 2'd1;
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_sel   <= 1'b0;
            r_last  <= 1'b1;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_flush <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_any) begin
                r_sel   <= l_gnt;
                r_last  <= l_gnt;
                r_we    <= mem_we;
                r_err   <= ~w_aligned;
                r_flush <= 1'b0;
                r_rdata <= '0;
            end else begin
                if (r_state == S_WAIT && r_cnt == 2'd0)
                    r_rdata <= r_we ? '0 : mem_rdata;
                // a flush anywhere in the fetch's lifetime kills its response
                if (r_state != S_IDLE && !r_sel && f_flush)
                    r_flush <= 1'b1;
            end
        end
    end

    always_comb begin
        w_resp   = (r_state == S_RESP) & ~reset;
        f_rvalid = w_resp & ~r_sel & ~r_flush & ~f_flush;
        f_err    = f_rvalid & r_err;
        f_rdata  = f_rvalid ? r_rdata : '0;
        l_rvalid = w_resp & r_sel;
        l_err    = l_rvalid & r_err;
        l_rdata  = l_rvalid ? r_rdata : '0;
    end

endmodule

// File: tb/tb_riscv_imem_arb.sv
// Bench for riscv_imem_arb: instance 0 at MEM_LAT=1, instance 1 at MEM_LAT=3, directed cases then random traffic.
// A transaction-level model (grant/due/free cycles) is compared against both instances every cycle.
module tb_riscv_imem_arb;

    logic        clk;
    logic        reset   [2];
    logic        f_req   [2];
    logic [14:0] f_addr  [2];
    logic        f_flush [2];
    logic        f_gnt   [2];
    logic        f_rvalid[2];
    logic        f_err   [2];
    logic [31:0] f_rdata [2];
    logic        l_req   [2];
    logic        l_we    [2];
    logic [14:0] l_addr  [2];
    logic [31:0] l_wdata [2];
    logic        l_gnt   [2];
    logic        l_rvalid[2];
    logic        l_err   [2];
    logic [31:0] l_rdata [2];
    logic        mem_en  [2];
    logic        mem_we  [2];
    logic [12:0] mem_addr[2];
    logic [31:0] mem_wdata[2];
    logic [31:0] mem_rdata[2];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic phase = 1'b0;

    riscv_imem_arb #(.PC_WIDTH(15), .INST_WIDTH(32), .MEM_LAT(1)) u_dut0 (
        .clk(clk), .reset(reset[0]),
        .f_req(f_req[0]), .f_addr(f_addr[0]), .f_flush(f_flush[0]),
        .f_gnt(f_gnt[0]), .f_rvalid(f_rvalid[0]), .f_err(f_err[0]), .f_rdata(f_rdata[0]),
        .l_req(l_req[0]), .l_we(l_we[0]), .l_addr(l_addr[0]), .l_wdata(l_wdata[0]),
        .l_gnt(l_gnt[0]), .l_rvalid(l_rvalid[0]), .l_err(l_err[0]), .l_rdata(l_rdata[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
    );

    riscv_imem_arb #(.PC_WIDTH(15), .INST_WIDTH(32), .MEM_LAT(3)) u_dut1 (
        .clk(clk), .reset(reset[1]),
        .f_req(f_req[1]), .f_addr(f_addr[1]), .f_flush(f_flush[1]),
        .f_gnt(f_gnt[1]), .f_rvalid(f_rvalid[1]), .f_err(f_err[1]), .f_rdata(f_rdata[1]),
        .l_req(l_req[1]), .l_we(l_we[1]), .l_addr(l_addr[1]), .l_wdata(l_wdata[1]),
        .l_gnt(l_gnt[1]), .l_rvalid(l_rvalid[1]), .l_err(l_err[1]), .l_rdata(l_rdata[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] init_word(input int k);
        return (k == 4) ? 32'h0050_0093 : 32'h0000_0013 + 32'(k) * 32'h0001_0001;
    endfunction

    function automatic logic [14:0] rnd_addr();
        logic [14:0] a;
        a = 15'($urandom_range(0, 63) * 4);
        if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    // bench-side memory that answers the DUT, and an independent model memory
    logic [31:0] tm [2][64];
    logic [31:0] mm [2][64];
    int          rd_due [2];
    logic [31:0] rd_dat [2];

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++)
            mem_rdata[i] = (rd_due[i] == cyc) ? rd_dat[i] : $urandom;
    end

    // transaction-level model state
    int          m_free [2];
    int          m_due  [2];
    logic        m_act  [2];
    logic        m_side [2];
    logic        m_fl   [2];
    logic        m_last [2];
    logic        m_err  [2];
    logic [31:0] m_dat  [2];
    logic        fg_seen[2];
    logic        lg_seen[2];

    task automatic model_step(input int i);
        logic        efg, efv, efe, elg, elv, ele, eme, emw, fr, lr, win;
        logic [31:0] efd, eld, emd;
        logic [12:0] ema;
        logic [14:0] a;
        logic [116:0] ev, gv;
        int w;
        efg = 0; efv = 0; efe = 0; elg = 0; elv = 0; ele = 0; eme = 0; emw = 0;
        efd = 0; eld = 0; emd = 0; ema = 0;
        if (reset[i]) begin
            m_act[i]  = 0;
            m_free[i] = cyc + 1;
            m_last[i] = 1;
        end else begin
            if (m_act[i] && !m_side[i] && f_flush[i]) m_fl[i] = 1;
            if (m_act[i] && cyc == m_due[i]) begin
                if (m_side[i]) begin
                    elv = 1; ele = m_err[i]; eld = m_dat[i];
                end else if (!m_fl[i]) begin
                    efv = 1; efe = m_err[i]; efd = m_dat[i];
                end
                m_act[i] = 0;
            end
            fr = f_req[i] & ~f_flush[i];
            lr = l_req[i];
            if (cyc >= m_free[i] && (fr || lr)) begin
                win = lr && (!fr || !m_last[i]);
                a = win ? l_addr[i] : f_addr[i];
                if (win) elg = 1; else efg = 1;
                m_last[i] = win; m_act[i] = 1; m_side[i] = win; m_fl[i] = 0;
                if (a[1:0] == 2'b00) begin
                    eme = 1; emw = win && l_we[i]; ema = a[14:2]; emd = l_wdata[i];
                    w = int'(a[7:2]);
                    if (emw) begin
                        m_dat[i] = 0; mm[i][w] = l_wdata[i];
                    end else begin
                        m_dat[i] = mm[i][w];
                    end
                    m_err[i]  = 0;
                    m_due[i]  = cyc + lat(i) + 1;
                    m_free[i] = cyc + lat(i) + 2;
                end else begin
                    m_err[i] = 1; m_dat[i] = 0;
                    m_due[i] = cyc + 1; m_free[i] = cyc + 2;
                end
            end
        end
        ev = {efg, efv, efe, efd, elg, elv, ele, eld, eme, emw, ema, emd};
        gv = {f_gnt[i], f_rvalid[i], f_err[i], f_rdata[i], l_gnt[i], l_rvalid[i], l_err[i],
              l_rdata[i], mem_en[i], mem_we[i], mem_addr[i], mem_wdata[i]};
        n_chk++;
        if (gv !== ev) begin
            n_fail++;
            $display("FAIL model_cmp inst%0d cyc%0d: got %h expected %h", i, cyc, gv, ev);
        end
        if (mem_en[i] === 1'b1) begin
            if (mem_we[i]) tm[i][mem_addr[i][5:0]] = mem_wdata[i];
            else begin
                rd_due[i] = cyc + lat(i);
                rd_dat[i] = tm[i][mem_addr[i][5:0]];
            end
        end
        fg_seen[i] = f_gnt[i];
        lg_seen[i] = l_gnt[i];
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
    end

    always @(posedge clk) begin
        #2;
        if (phase) begin
            for (int i = 0; i < 2; i++) begin
                reset[i]   = ($urandom_range(0, 99) == 0);
                f_flush[i] = ($urandom_range(0, 9) == 0);
                if (!f_req[i] || fg_seen[i]) begin
                    f_req[i]  = ($urandom_range(0, 2) == 0);
                    f_addr[i] = rnd_addr();
                end
                if (!l_req[i] || lg_seen[i]) begin
                    l_req[i]   = ($urandom_range(0, 2) == 0);
                    l_we[i]    = 1'($urandom_range(0, 1));
                    l_addr[i]  = rnd_addr();
                    l_wdata[i] = $urandom;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 64; k++) begin
                tm[i][k] = init_word(k);
                mm[i][k] = init_word(k);
            end
            reset[i] = 1; f_req[i] = 0; f_addr[i] = 0; f_flush[i] = 0;
            l_req[i] = 0; l_we[i] = 0; l_addr[i] = 0; l_wdata[i] = 0;
            mem_rdata[i] = 0; rd_due[i] = -1;
            m_free[i] = 0; m_due[i] = 0; m_act[i] = 0; m_side[i] = 0; m_fl[i] = 0;
            m_last[i] = 1; m_err[i] = 0; m_dat[i] = 0; fg_seen[i] = 0; lg_seen[i] = 0;
        end
        f_req[0] = 1; f_addr[0] = 15'h0010;
        l_req[0] = 1; l_addr[0] = 15'h0020;
        repeat (3) nxt();
        smp();
        chk("rst_ctl", {24'h0, f_gnt[0], l_gnt[0], f_rvalid[0], f_err[0],
                        l_rvalid[0], l_err[0], mem_en[0], mem_we[0]}, 32'h0);

        // both requesting from reset release: fetch first, then alternation every 3 cycles
        nxt(); reset[0] = 0; reset[1] = 0;
        smp();
        chk("rr_T_fgnt", {31'h0, f_gnt[0]}, 1);
        chk("rr_T_lgnt", {31'h0, l_gnt[0]}, 0);
        chk("fetch_mem_addr", {19'h0, mem_addr[0]}, 32'h004);
        for (int k = 1; k <= 9; k++) begin
            nxt(); smp();
            chk($sformatf("rr_T%0d_fgnt", k), {31'h0, f_gnt[0]}, (k == 6) ? 1 : 0);
            chk($sformatf("rr_T%0d_lgnt", k), {31'h0, l_gnt[0]}, (k == 3 || k == 9) ? 1 : 0);
            if (k == 2) chk("fetch_rdata", f_rdata[0], 32'h0050_0093);
            if (k == 5) chk("load_rdata", l_rdata[0], 32'h0008_001B);
        end
        nxt(); f_req[0] = 0; l_req[0] = 0;
        repeat (4) nxt();

        // loader write, then read it back
        l_req[0] = 1; l_we[0] = 1; l_addr[0] = 15'h0020; l_wdata[0] = 32'hDEAD_BEEF;
        smp();
        chk("wr_mem_en", {31'h0, mem_en[0]}, 1);
        chk("wr_mem_we", {31'h0, mem_we[0]}, 1);
        chk("wr_mem_addr", {19'h0, mem_addr[0]}, 32'h008);
        chk("wr_mem_wdata", mem_wdata[0], 32'hDEAD_BEEF);
        nxt(); l_req[0] = 0; l_we[0] = 0;
        nxt(); smp();
        chk("wr_rvalid", {31'h0, l_rvalid[0]}, 1);
        chk("wr_rdata", l_rdata[0], 32'h0);
        nxt(); l_req[0] = 1; l_addr[0] = 15'h0020;
        smp();
        chk("rb_gnt", {31'h0, l_gnt[0]}, 1);
        nxt(); l_req[0] = 0;
        nxt(); smp();
        chk("rb_rdata", l_rdata[0], 32'hDEAD_BEEF);

        // misaligned fetch
        nxt(); f_req[0] = 1; f_addr[0] = 15'h0006;
        smp();
        chk("mis_gnt", {31'h0, f_gnt[0]}, 1);
        chk("mis_mem_en", {31'h0, mem_en[0]}, 0);
        nxt(); f_req[0] = 0;
        smp();
        chk("mis_resp", {29'h0, f_rvalid[0], f_err[0], |f_rdata[0]}, 32'h6);
        nxt(); smp();
        chk("mis_one_cycle", {31'h0, f_rvalid[0]}, 0);

        // MEM_LAT=3 fetch flushed at T+2; loader waits until T+5
        nxt(); f_req[1] = 1; f_addr[1] = 15'h0010;
        smp();
        chk("fl_gnt", {31'h0, f_gnt[1]}, 1);
        nxt(); f_req[1] = 0;
        nxt(); f_flush[1] = 1;
        nxt(); f_flush[1] = 0; l_req[1] = 1; l_we[1] = 0; l_addr[1] = 15'h0024;
        smp();
        chk("fl_T3_lgnt", {31'h0, l_gnt[1]}, 0);
        nxt(); smp();
        chk("fl_T4_rvalid", {30'h0, f_rvalid[1], l_gnt[1]}, 0);
        nxt(); smp();
        chk("fl_T5_lgnt", {31'h0, l_gnt[1]}, 1);
        nxt(); l_req[1] = 0;

        // reset mid-fetch drops the response; tie afterwards goes to fetch
        nxt(); f_req[0] = 1; f_addr[0] = 15'h0010;
        smp();
        chk("mr_gnt", {31'h0, f_gnt[0]}, 1);
        nxt(); reset[0] = 1; l_req[0] = 1; l_we[0] = 0; l_addr[0] = 15'h0028;
        smp();
        chk("mr_rst_ctl", {24'h0, f_gnt[0], l_gnt[0], f_rvalid[0], f_err[0],
                           l_rvalid[0], l_err[0], mem_en[0], mem_we[0]}, 32'h0);
        chk("mr_rst_data", f_rdata[0] | l_rdata[0] | mem_wdata[0] | {19'h0, mem_addr[0]}, 32'h0);
        nxt(); reset[0] = 0;
        smp();
        chk("mr_after_fgnt", {31'h0, f_gnt[0]}, 1);
        chk("mr_after_lgnt", {31'h0, l_gnt[0]}, 0);
        chk("mr_no_rvalid", {31'h0, f_rvalid[0]}, 0);
        nxt(); f_req[0] = 0;
        phase = 1;

        repeat (4000) @(posedge clk);
        phase = 0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
